// File: rtl/serial_async_rx.sv
// Asynchronous serial receiver: 1 start bit, p_WIDTH data bits LSB first,
// 1 stop bit, p_PERIOD clocks per bit. The received word is held in a
// single-entry buffer with a full/read handshake to the consumer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle; waits for a falling edge while armed
// START | counting to mid start bit; rejects glitches
// DATA  | sampling p_WIDTH data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; load word, flag overrun or frame error
module serial_async_rx #(
  parameter int p_WIDTH  = 8,
  parameter int p_PERIOD = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_read,
  output logic [p_WIDTH-1:0] ov_data,
  output logic               o_full,
  output logic               o_busy,
  output logic               o_frame_err,
  output logic               o_overrun
);

  localparam int CW = (p_PERIOD > 2) ? $clog2(p_PERIOD) : 1;
  localparam int IW = (p_WIDTH > 1) ? $clog2(p_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(p_PERIOD / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(p_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(p_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [p_WIDTH-1:0] shift_q, shift_d;
  logic               armed_q, armed_d;
  logic [p_WIDTH-1:0] data_q, data_d;
  logic               full_q, full_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               s_rx;

  assign s_rx = sync2_q;

  // State register and all datapath flops, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      full_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      full_q  <= full_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, bit timing, shift register and buffer handshake.
  always_comb begin
    state_d = state_q;
    sync1_d = i_rx;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    armed_d = armed_q;
    data_d  = data_q;
    full_d  = full_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (i_read) begin
      full_d = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (s_rx) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          cnt_d   = CNT_HALF;
          armed_d = 1'b0;
        end
      end
      START: begin
        // The cycle spent detecting the edge counts toward the half bit,
        // so the start sample fires as the counter steps down to zero.
        if (cnt_q <= CNT_ONE) begin
          cnt_d = '0;
          if (!s_rx) begin
            state_d = DATA;
            cnt_d   = CNT_LAST;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = s_rx;
          cnt_d          = CNT_LAST;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (s_rx) begin
            // Stop bit re-arms immediately so back-to-back frames work.
            armed_d = 1'b1;
            if (!full_q || i_read) begin
              data_d = shift_q;
              full_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs taken straight from registered state.
  always_comb begin
    o_busy      = (state_q != IDLE);
    ov_data     = data_q;
    o_full      = full_q;
    o_frame_err = ferr_q;
    o_overrun   = ovr_q;
  end

endmodule

// File: tb/tb_serial_async_rx.sv
// Bench for serial_async_rx: three receivers (p_PERIOD 2, 16, 3) driven by
// a behavioural transmitter task, checked against tables, hand sequences
// and a buffer-level reference model.
module tb_serial_async_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx [3];
  logic       rd [3];
  logic [7:0] dat [3];
  logic       full [3];
  logic       busy [3];
  logic       ferr [3];
  logic       ovr [3];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_start = 0;
  int ferr_cnt [3] = '{0, 0, 0};
  int rise_cyc [3] = '{-1, -1, -1};
  logic full_prev [3] = '{1'b0, 1'b0, 1'b0};

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    logic       rd_first;
    logic [7:0] e_data;
    logic       e_full;
    logic       e_ovr;
    int         e_ferr;
  } vec_t;

  vec_t tbl [8];

  serial_async_rx #(.p_WIDTH(8), .p_PERIOD(2)) u_p2 (
    .i_clk(clk), .i_reset(rst_n), .i_rx(rx[0]), .i_read(rd[0]),
    .ov_data(dat[0]), .o_full(full[0]), .o_busy(busy[0]),
    .o_frame_err(ferr[0]), .o_overrun(ovr[0]));

  serial_async_rx #(.p_WIDTH(8), .p_PERIOD(16)) u_p16 (
    .i_clk(clk), .i_reset(rst_n), .i_rx(rx[1]), .i_read(rd[1]),
    .ov_data(dat[1]), .o_full(full[1]), .o_busy(busy[1]),
    .o_frame_err(ferr[1]), .o_overrun(ovr[1]));

  serial_async_rx #(.p_WIDTH(8), .p_PERIOD(3)) u_p3 (
    .i_clk(clk), .i_reset(rst_n), .i_rx(rx[2]), .i_read(rd[2]),
    .ov_data(dat[2]), .o_full(full[2]), .o_busy(busy[2]),
    .o_frame_err(ferr[2]), .o_overrun(ovr[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count frame-error pulses and note the cycle each o_full rises.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ferr[i] === 1'b1) ferr_cnt[i]++;
      if (full[i] === 1'b1 && full_prev[i] !== 1'b1) rise_cyc[i] = cyc;
      full_prev[i] = full[i];
    end
  end

  function automatic int per_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 16 : 3);
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(int k, logic [7:0] d, logic stopb);
    int p;
    p = per_of(k);
    last_start = cyc;
    rx[k] = 1'b0;
    tick(p);
    for (int b = 0; b < 8; b++) begin
      rx[k] = d[b];
      tick(p);
    end
    rx[k] = stopb;
    tick(p);
  endtask

  task automatic pulse_read(int k);
    rd[k] = 1'b1;
    tick(1);
    rd[k] = 1'b0;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [7:0] mdl_data;
  logic       mdl_full;
  logic       mdl_ovr;
  int         mdl_ferr;
  int         f0;
  int         t0;
  logic [7:0] rb;
  logic       rgood;

  initial begin
    tbl[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 0};
    tbl[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0};
    tbl[2] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 0};
    tbl[3] = '{8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 0};
    tbl[4] = '{8'hC3, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1};
    tbl[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    tbl[6] = '{8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 0};
    tbl[7] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx[k] = 1'b1;
      rd[k] = 1'b0;
    end
    tick(1);

    // Reset held with the line toggling.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) rx[k] = ~rx[k];
      tick(1);
      chk("reset_outs_p2", 32'({dat[0], full[0], busy[0], ferr[0], ovr[0]}), 32'h0);
      chk("reset_outs_p16", 32'({dat[1], full[1], busy[1], ferr[1], ovr[1]}), 32'h0);
    end
    for (int k = 0; k < 3; k++) rx[k] = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk("post_reset_idle", 32'({full[0], busy[0]}), 32'h0);
    send(0, 8'h55, 1'b1);
    tick(3);
    chk("first_word_data", 32'(dat[0]), 32'h55);
    chk("first_word_full", 32'(full[0]), 32'h1);

    // Table of single frames on the period-2 receiver.
    for (int i = 0; i < 8; i++) begin
      f0 = ferr_cnt[0];
      if (tbl[i].rd_first) pulse_read(0);
      send(0, tbl[i].d, tbl[i].stopb);
      rx[0] = 1'b1;
      tick(3);
      chk("tbl_data", 32'(dat[0]), 32'(tbl[i].e_data));
      chk("tbl_full", 32'(full[0]), 32'(tbl[i].e_full));
      chk("tbl_ovr", 32'(ovr[0]), 32'(tbl[i].e_ovr));
      chk("tbl_ferr", 32'(ferr_cnt[0] - f0), 32'(tbl[i].e_ferr));
    end

    // Back-to-back frames without a read: second word overruns.
    pulse_read(0);
    send(0, 8'h11, 1'b1);
    send(0, 8'h22, 1'b1);
    tick(3);
    chk("b2b_data", 32'(dat[0]), 32'h11);
    chk("b2b_flags", 32'({full[0], ovr[0]}), 32'h3);
    pulse_read(0);
    chk("b2b_read_clear", 32'({full[0], ovr[0]}), 32'h0);

    // One-cycle low glitch.
    f0 = ferr_cnt[0];
    rx[0] = 1'b0;
    tick(1);
    rx[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_seen", 32'(busy[0]), 32'h1);
    tick(10);
    chk("glitch_idle", 32'({full[0], busy[0]}), 32'h0);
    chk("glitch_no_ferr", 32'(ferr_cnt[0] - f0), 32'h0);

    // Read on the exact stop-sample cycle while full.
    send(0, 8'h44, 1'b1);
    tick(3);
    chk("pre_sim_full", 32'(full[0]), 32'h1);
    send(0, 8'h7E, 1'b1);
    tick(1);
    rd[0] = 1'b1;
    tick(1);
    rd[0] = 1'b0;
    tick(2);
    chk("sim_data", 32'(dat[0]), 32'h7E);
    chk("sim_flags", 32'({full[0], ovr[0]}), 32'h2);

    // Bad stop bit followed by a long break.
    pulse_read(0);
    f0 = ferr_cnt[0];
    send(0, 8'h3C, 1'b0);
    tick(40);
    chk("break_not_busy", 32'(busy[0]), 32'h0);
    rx[0] = 1'b1;
    tick(20);
    chk("break_ferr_once", 32'(ferr_cnt[0] - f0), 32'h1);
    chk("break_not_full", 32'(full[0]), 32'h0);
    send(0, 8'h81, 1'b1);
    tick(3);
    chk("after_break_data", 32'(dat[0]), 32'h81);
    chk("after_break_full", 32'(full[0]), 32'h1);

    // Latency at p_PERIOD=16 and p_PERIOD=3 (2 synchroniser cycles + P/2 + 9P + 1).
    send(1, 8'hA5, 1'b1);
    t0 = last_start;
    tick(3);
    chk("p16_latency", 32'(rise_cyc[1] - t0), 32'(2 + 8 + 9 * 16 + 1));
    chk("p16_data", 32'(dat[1]), 32'hA5);
    send(2, 8'hA5, 1'b1);
    t0 = last_start;
    tick(3);
    chk("p3_latency", 32'(rise_cyc[2] - t0), 32'(2 + 1 + 9 * 3 + 1));
    chk("p3_data", 32'({full[2], dat[2]}), 32'h1A5);

    // Loopback sweep of 256 words with a read after each.
    pulse_read(0);
    f0 = ferr_cnt[0];
    for (int i = 0; i < 256; i++) begin
      send(0, 8'(8'hAA + i), 1'b1);
      tick(3);
      chk("loop_data", 32'(dat[0]), 32'(8'(8'hAA + i)));
      chk("loop_flags", 32'({full[0], ovr[0]}), 32'h2);
      pulse_read(0);
    end
    chk("loop_no_ferr", 32'(ferr_cnt[0] - f0), 32'h0);

    // Randomised frames against a buffer-level model.
    mdl_data = 8'hA9;
    mdl_full = 1'b0;
    mdl_ovr  = 1'b0;
    mdl_ferr = ferr_cnt[0];
    for (int i = 0; i < 60; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rgood = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) begin
        pulse_read(0);
        mdl_full = 1'b0;
        mdl_ovr  = 1'b0;
      end
      send(0, rb, rgood);
      rx[0] = 1'b1;
      tick($urandom_range(3, 6));
      if (rgood) begin
        if (!mdl_full) begin
          mdl_data = rb;
          mdl_full = 1'b1;
        end else begin
          mdl_ovr = 1'b1;
        end
      end else begin
        mdl_ferr++;
      end
      chk("rand_data", 32'(dat[0]), 32'(mdl_data));
      chk("rand_flags", 32'({full[0], ovr[0]}), 32'({mdl_full, mdl_ovr}));
      chk("rand_ferr", 32'(ferr_cnt[0]), 32'(mdl_ferr));
    end

    // Reset in the middle of the data bits abandons the frame.
    pulse_read(0);
    rx[0] = 1'b0;
    tick(6);
    chk("mid_busy", 32'(busy[0]), 32'h1);
    rx[0] = 1'b1;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(30);
    chk("mid_reset_nothing", 32'({dat[0], full[0], busy[0]}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_async_rx.md
Name: serial_async_rx

Overview:
- Asynchronous serial receiver. It is the receive end of the link driven by SerialAsyncTx and uses the same parameters and frame format.
- Deserialises one frame from the line `i_rx` into a parallel word.
- Holds the word in a single-entry output buffer, with a full/read handshake to the consumer.
- Paired with SerialAsyncTx in the SerialRxTx loopback bench.

Parameters:
- p_WIDTH, 8, data bits per frame (>= 1).
- p_PERIOD, 2, clock cycles per serial bit (>= 2). Must equal the transmitter's p_PERIOD.

Ports:
- i_clk  input  1  clock; all logic on its rising edge.
- i_reset  input  1  synchronous reset, active-low (0 = reset).
- i_rx  input  1  serial line; idle high; asynchronous to i_clk.
- i_read  input  1  consumer acknowledge; clears the buffer.
- ov_data  output  p_WIDTH  last good received word.
- o_full  output  1  ov_data holds an unread word.
- o_busy  output  1  a frame is being received (state != IDLE).
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  sticky: a good frame arrived while o_full=1.

Behaviour:
- Frame format:
  - 1 start bit (0), then p_WIDTH data bits LSB first, then 1 stop bit (1).
  - Each bit lasts p_PERIOD cycles. No parity.
- Input synchronisation:
  - i_rx passes through a 2-flop synchroniser, reset value 1. Call the result s_rx.
  - All latencies below are referenced to s_rx.
- Reset (i_reset=0 at a clock edge):
  - State goes to IDLE. ov_data=0, o_full=0, o_busy=0, o_frame_err=0, o_overrun=0.
  - Synchroniser flops are set to 1 and the bit counter to 0.
  - Reset applied mid-frame abandons the frame; nothing is written.
- Bit-timing counter:
  - Counts 0..p_PERIOD-1; width is clog2(p_PERIOD), minimum 1.
  - Bit index counts 0..p_WIDTH-1.
- IDLE:
  - Go to START when s_rx=0 and the armed flag is set. Counter loads with p_PERIOD/2 (integer division).
  - The armed flag sets whenever s_rx=1 is seen in IDLE, and clears on entry to START.
- START:
  - Counter decrements; when it reaches 0, sample s_rx.
  - s_rx=0: go to DATA, counter = p_PERIOD-1, bit index = 0.
  - s_rx=1: glitch. Return to IDLE with no flags set.
- DATA:
  - Each time the counter reaches 0, shift s_rx into shift-register bit[index] and reload counter = p_PERIOD-1.
  - After bit index p_WIDTH-1, go to STOP.
  - Consecutive samples are therefore exactly p_PERIOD cycles apart, at mid-bit.
- STOP: when the counter reaches 0, sample s_rx.
  - Sample = 1, o_full=0 (or i_read=1 this cycle): ov_data <= shift register and o_full <= 1 on the next edge. Return to IDLE, still armed.
  - Sample = 1, o_full=1 and i_read=0: the new word is discarded. ov_data is unchanged and o_overrun <= 1.
  - Sample = 0: o_frame_err = 1 for exactly one cycle; data discarded; return to IDLE unarmed. A break or stuck-low line therefore does not retrigger until s_rx returns to 1.
- Latency: o_full rises 1 cycle after the stop sample. The stop sample is p_PERIOD/2 + (p_WIDTH+1)*p_PERIOD cycles after the s_rx falling edge.
- Back-to-back frames: the stop bit re-arms the receiver, so a start bit immediately following the stop bit is received with no gap required.
- i_read:
  - Clears o_full and o_overrun on the next edge.
  - i_read while o_full=0 has no effect.
  - i_read in the same cycle as a good stop sample: the new word loads, o_full stays 1, o_overrun is not set.
- o_busy = 1 in START, DATA and STOP.

Test Plan:
- Bench parameters are p_WIDTH=8, p_PERIOD=2 unless stated.
- Reset: hold i_reset=0 for 3 cycles with i_rx toggling -> all outputs 0 and no frame started. Release, then send 0x55 -> ov_data=0x55, o_full=1.
- Loopback with SerialAsyncTx: send 0xAA+i for i=0..255, pulsing i_read after each word -> every ov_data matches, o_frame_err and o_overrun never assert.
- Timing check with p_PERIOD=16: drive the frame for 0xA5 bit-by-bit -> o_full rises exactly 8+9*16+1 cycles after s_rx falls. Repeat at p_PERIOD=3 -> data still 0xA5.
- Frame error: send 0x3C with stop bit 0, then hold the line low for 40 cycles, then high -> one o_frame_err pulse, o_full=0, no second frame. A following 0x81 is received correctly.
- Overrun and glitch:
  - Send 0x11 then 0x22 without i_read -> ov_data=0x11, o_overrun=1. i_read -> both flags clear.
  - 1-cycle low glitch on i_rx -> no o_full, o_busy returns to 0.
- Simultaneous events:
  - Assert i_read on the stop-sample cycle of 0x7E while o_full=1 -> ov_data=0x7E, o_full=1, o_overrun=0.
  - Reset asserted mid-DATA -> no word written.
